anode_scanner: RTL

//   Parametrised time-multiplexed anode driver for an N-digit common-cathode-bus
//   7-segment display. Steps through the digits at a fixed refresh rate.

---
 rtl/display_pkg.sv | 22 ++
 rtl/anode_scanner_if.sv | 20 ++
 rtl/anode_scanner_decoder.sv | 31 +++
 rtl/anode_scanner.sv | 114 +++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display path.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    // Widest display the one-hot helper can describe.
    localparam int MAX_DIGITS = 32;

    function automatic logic [MAX_DIGITS-1:0] onehot_n(input int idx, input int n);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            v[i] = (i < n) && (i == idx);
        end
        return v;
    endfunction

endpackage

// File: rtl/anode_scanner_if.sv
// Scanner-side bundle: control inputs plus registered anode/slot outputs.
interface anode_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                          enable;
    logic [NUM_DIGITS-1:0]         digit_mask;
    logic [NUM_DIGITS-1:0]         anode;
    logic [$clog2(NUM_DIGITS)-1:0] digit_sel;
    logic                          digit_strobe;

    modport master (
        output enable, digit_mask,
        input  anode, digit_sel, digit_strobe
    );

    modport slave (
        input  enable, digit_mask,
        output anode, digit_sel, digit_strobe
    );
endinterface

// File: rtl/anode_scanner_decoder.sv
// Index + valid to polarity-adjusted one-hot anode pattern (purely combinational).
module anode_decoder_n
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [$clog2(NUM_DIGITS)-1:0] idx,
    input  logic                          valid,
    output logic [NUM_DIGITS-1:0]         anode
);

    logic [MAX_DIGITS-1:0] oh_full;

    always_comb begin
        oh_full = '0;
        if (valid) begin
            oh_full = onehot_n(int'(idx), NUM_DIGITS);
        end
    end

    assign anode = ACTIVE_LOW ? ~oh_full[NUM_DIGITS-1:0] : oh_full[NUM_DIGITS-1:0];

    generate
        if (NUM_DIGITS < MAX_DIGITS) begin : g_spare
            logic unused_hi;
            assign unused_hi = |oh_full[MAX_DIGITS-1:NUM_DIGITS];
        end
    endgenerate

endmodule

// File: rtl/anode_scanner.sv
// Time-multiplexed anode driver: fixed-length digit slots, each opening with a
// dead-time blank, with per-digit masking and a global enable.
module anode_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    anode_scanner_if.slave   bus
);

    localparam int SW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2(REFRESH_DIV);

    localparam logic [TW-1:0]         TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0]         BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [SW-1:0]         SEL_LAST   = SW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

    generate
        if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
            $fatal(1, "anode_scanner: NUM_DIGITS out of range");
        end
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
            $fatal(1, "anode_scanner: need 1 <= BLANK_CYCLES < REFRESH_DIV");
        end
    endgenerate

    scan_state_t           state;
    scan_state_t           nstate;
    logic [TW-1:0]         tick;
    logic [SW-1:0]         sel;
    logic                  strobe;
    logic [NUM_DIGITS-1:0] mask_q;
    logic [NUM_DIGITS-1:0] anode_q;

    logic                  slot_start;
    logic [SW-1:0]         sel_next;
    logic [NUM_DIGITS-1:0] mask_next;
    logic                  drive_valid;
    logic [NUM_DIGITS-1:0] anode_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        if (!bus.enable) begin
            nstate = IDLE;
        end else begin
            case (state)
                IDLE:    nstate = BLANK;
                BLANK:   if (tick == BLANK_LAST) nstate = DRIVE;
                DRIVE:   if (tick == TICK_LAST)  nstate = BLANK;
                default: nstate = IDLE;
            endcase
        end
    end

    // Every register is loaded from next-state values so anode, digit_sel and
    // the strobe all change on the same edge as the slot boundary.
    always_comb begin
        slot_start = bus.enable && ((state == IDLE) || (state == DRIVE && tick == TICK_LAST));
        sel_next   = sel;
        if (slot_start) begin
            sel_next = (state == IDLE || sel == SEL_LAST) ? '0 : sel + 1'b1;
        end
        mask_next   = slot_start ? bus.digit_mask : mask_q;
        drive_valid = (nstate == DRIVE) && mask_next[sel_next];
    end

    anode_decoder_n #(
        .NUM_DIGITS (NUM_DIGITS),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_decoder (
        .idx   (sel_next),
        .valid (drive_valid),
        .anode (anode_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tick    <= '0;
            sel     <= '0;
            strobe  <= 1'b0;
            mask_q  <= '0;
            anode_q <= ANODE_OFF;
        end else begin
            strobe  <= slot_start;
            sel     <= sel_next;
            mask_q  <= mask_next;
            anode_q <= anode_next;
            if (slot_start || nstate == IDLE) begin
                tick <= '0;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

    assign bus.anode        = anode_q;
    assign bus.digit_sel    = sel;
    assign bus.digit_strobe = strobe;

endmodule
